// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core front end.
//   XLEN          : default data/address width
//   RESET_PC      : default first fetch address after reset
//   NOP_INSTR     : canonical NOP (addi x0, x0, 0) shown when no instruction is held
//   fetch_state_t : fetch sequencing states
package riscv_pkg;

    localparam int              XLEN      = 32;
    localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0]     NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with show-ahead read and a synchronous flush.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (control state only)
//   clear      : empties the FIFO; takes priority over push and pop
//   push, din  : write request and data (ignored when full unless popping)
//   pop        : read request (ignored when empty)
//   dout       : head entry, valid whenever count != 0
//   count      : current occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    // A full FIFO can still accept a write when the head leaves in the same cycle.
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage carries no reset; entries are only observed once written.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word reads to instruction
// memory, buffers returned words and hands {pc, instr} to decode.
// Ports:
//   clk, rst_n                          : clock, asynchronous active-low reset
//   imem_req_valid/ready/addr           : fetch request handshake (addr word aligned)
//   imem_resp_valid/data                : in-order read responses
//   pc_source, redirect_target          : redirect from the control unit
//   instr_valid/ready, instr, instr_pc  : decode-side handshake
//   fetch_misaligned                    : only with FETCH_MISALIGN_TRAP_EN defined;
//                                         sticky flag for a misaligned redirect
// Build option: FETCH_MISALIGN_TRAP_EN. When undefined, redirect_target[1:0]
// is ignored and the fetch address is forced word aligned.
module fetch_unit #(
    parameter int              XLEN       = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC   = XLEN'(riscv_pkg::RESET_PC),
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    input  logic            pc_source,
    input  logic [XLEN-1:0] redirect_target,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic            fetch_misaligned
`endif
);

    import riscv_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = XLEN + 32;

    fetch_state_t    state;
    fetch_state_t    state_nxt;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] redirect_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   out_nxt;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   ibuf_count;
    logic [CW-1:0]   aq_count;
    logic [BW-1:0]   ibuf_din;
    logic [BW-1:0]   ibuf_dout;
    logic [XLEN-1:0] aq_dout;
    logic            ibuf_empty;
    logic            req_fire;
    logic            resp_in;
    logic            credit_ok;
    logic            fetch_blocked;
    logic            ibuf_push;
    logic            ibuf_pop;
    logic            aq_pop;

    // A response with nothing outstanding cannot belong to this unit.
    assign resp_in  = imem_resp_valid && (outstanding != '0);
    assign req_fire = imem_req_valid && imem_req_ready;
    assign out_nxt  = outstanding + CW'(req_fire) - CW'(resp_in);

    // Every accepted request reserves a buffer slot, so responses never overflow.
    assign credit_ok = ({1'b0, outstanding} + {1'b0, ibuf_count}) < (CW+1)'(FIFO_DEPTH);

`ifdef FETCH_MISALIGN_TRAP_EN
    assign redirect_pc   = redirect_target;
    assign fetch_blocked = fetch_misaligned;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         fetch_misaligned <= 1'b0;
        else if (pc_source) fetch_misaligned <= (redirect_target[1:0] != 2'b00);
    end
`else
    logic redirect_lsb_unused;
    assign redirect_lsb_unused = ^redirect_target[1:0];
    assign redirect_pc   = {redirect_target[XLEN-1:2], 2'b00};
    assign fetch_blocked = 1'b0;
`endif

    assign imem_req_valid = (state == RUN) && credit_ok && !fetch_blocked;
    assign imem_req_addr  = fetch_pc;

    assign ibuf_empty  = (ibuf_count == '0);
    assign instr_valid = !ibuf_empty && !fetch_blocked;
    assign instr       = ibuf_empty ? NOP_INSTR : ibuf_dout[31:0];
    assign instr_pc    = ibuf_empty ? '0 : ibuf_dout[BW-1:32];

    // Only RUN-state responses belong to the current path; the address queue
    // tags each one with the PC it was fetched from.
    assign ibuf_push = resp_in && (state == RUN);
    assign ibuf_pop  = instr_valid && instr_ready;
    assign ibuf_din  = {aq_dout, imem_resp_data};
    assign aq_pop    = resp_in && (state == RUN) && (aq_count != '0);

    // Redirect clears both queues; clear beats a same-cycle push, so a request
    // accepted or a response returned in the redirect cycle is treated as stale.
    sync_fifo #(.WIDTH(BW), .DEPTH(FIFO_DEPTH)) u_ibuf (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (pc_source),
        .push  (ibuf_push),
        .pop   (ibuf_pop),
        .din   (ibuf_din),
        .dout  (ibuf_dout),
        .count (ibuf_count)
    );

    sync_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH)) u_addr_q (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (pc_source),
        .push  (req_fire),
        .pop   (aq_pop),
        .din   (fetch_pc),
        .dout  (aq_dout),
        .count (aq_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= BOOT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            BOOT:    state_nxt = RUN;
            RUN:     if (pc_source && (out_nxt != '0)) state_nxt = FLUSH;
            FLUSH:   if ((drop_cnt == '0) || (resp_in && (drop_cnt == CW'(1)))) state_nxt = RUN;
            default: state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= out_nxt;
            if (pc_source)     fetch_pc <= redirect_pc;
            else if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
            // In FLUSH a further redirect leaves the drop count alone.
            if (pc_source && (state != FLUSH))
                drop_cnt <= out_nxt;
            else if ((state == FLUSH) && resp_in && (drop_cnt != '0))
                drop_cnt <= drop_cnt - CW'(1);
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        pc_source;
    logic [31:0] redirect_target;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fetch_misaligned;
`endif

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .pc_source       (pc_source),
        .redirect_target (redirect_target),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .instr_pc        (instr_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .fetch_misaligned(fetch_misaligned)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } mreq_t;

    // Reference model: memory in-flight list, expected in-order delivery
    // queue of current-path addresses, and the architectural next fetch PC.
    mreq_t       mem_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] acc_addr[$];
    int          acc_cyc[$];
    logic [31:0] pop_log[$];
    int          cur_inflight;
    int          stale_cnt;
    logic [31:0] model_pc;
    bit          booted;
    bit          mis;
    int          cyc;
    int          since_rst;
    int          lat_min;
    int          lat_max;
    int          n_cmp;
    int          n_fail;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic model_reset();
        mem_q.delete();
        exp_q.delete();
        acc_addr.delete();
        acc_cyc.delete();
        pop_log.delete();
        cur_inflight = 0;
        stale_cnt    = 0;
        model_pc     = 32'h0;
        booted       = 0;
        mis          = 0;
        since_rst    = 0;
    endtask

    // One clock cycle: entered and left just after a falling edge with the
    // caller's inputs already applied.
    task automatic tick();
        bit          resp, fire, pop, redir, exp_req, exp_iv;
        logic [31:0] a, tgt;
        int          lat;
        resp = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        imem_resp_valid = resp;
        imem_resp_data  = resp ? mem_word(mem_q[0].addr) : $urandom();
        #1;
        exp_req = booted && (stale_cnt == 0) && !mis && (exp_q.size() < DEPTH);
        n_cmp++;
        if (imem_req_valid !== exp_req) begin
            n_fail++;
            $display("FAIL req_valid @%0t: got %b want %b", $time, imem_req_valid, exp_req);
        end
        if (exp_req && imem_req_valid) begin
            n_cmp++;
            if (imem_req_addr !== model_pc) begin
                n_fail++;
                $display("FAIL req_addr @%0t: got %h want %h", $time, imem_req_addr, model_pc);
            end
        end
        exp_iv = exp_q.size() > cur_inflight;
        n_cmp++;
        if (instr_valid !== exp_iv) begin
            n_fail++;
            $display("FAIL instr_valid @%0t: got %b want %b", $time, instr_valid, exp_iv);
        end
        if (exp_iv && instr_valid) begin
            n_cmp++;
            if (instr_pc !== exp_q[0] || instr !== mem_word(exp_q[0])) begin
                n_fail++;
                $display("FAIL instr_out @%0t: got pc=%h instr=%h want pc=%h instr=%h",
                         $time, instr_pc, instr, exp_q[0], mem_word(exp_q[0]));
            end
        end
        fire  = imem_req_valid && imem_req_ready;
        pop   = instr_valid && instr_ready;
        redir = pc_source;
        tgt   = redirect_target;
        a     = imem_req_addr;
        if (pop) pop_log.push_back(instr_pc);
        @(posedge clk);
        cyc++;
        since_rst++;
        if (resp) begin
            if (mem_q[0].stale) stale_cnt--;
            else                cur_inflight--;
            void'(mem_q.pop_front());
        end
        if (pop && exp_q.size() > 0) void'(exp_q.pop_front());
        if (fire) begin
            lat = $urandom_range(lat_max, lat_min);
            mem_q.push_back('{addr: a, due: cyc - 1 + lat, stale: 1'b0});
            exp_q.push_back(a);
            cur_inflight++;
            model_pc = model_pc + 32'd4;
            acc_addr.push_back(a);
            acc_cyc.push_back(since_rst);
        end
        if (redir) begin
            exp_q.delete();
            foreach (mem_q[i]) begin
                if (!mem_q[i].stale) begin
                    mem_q[i].stale = 1'b1;
                    stale_cnt++;
                end
            end
            cur_inflight = 0;
            model_pc = {tgt[31:2], 2'b00};
`ifdef FETCH_MISALIGN_TRAP_EN
            mis = (tgt[1:0] != 2'b00);
`endif
        end
        booted = 1;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        pc_source       = 1'b0;
        redirect_target = 32'h0;
        instr_ready     = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        n_cmp += 5;
        if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid: got %b want 0", imem_req_valid); end
        if (instr_valid !== 1'b0)    begin n_fail++; $display("FAIL rst_instr_valid: got %b want 0", instr_valid); end
        if (instr !== NOP)           begin n_fail++; $display("FAIL rst_instr: got %h want %h", instr, NOP); end
        if (instr_pc !== 32'h0)      begin n_fail++; $display("FAIL rst_instr_pc: got %h want 0", instr_pc); end
        if (imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL rst_req_addr: got %h want 0", imem_req_addr); end
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        lat_min = 1; lat_max = 1;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        repeat (10) tick();
        n_cmp++;
        if (acc_addr.size() < 3) begin
            n_fail++;
            $display("FAIL basic_count: got %0d accepts want >=3", acc_addr.size());
        end else begin
            n_cmp += 3;
            if (acc_cyc[0] !== 2)         begin n_fail++; $display("FAIL basic_first_cycle: got %0d want 2", acc_cyc[0]); end
            if (acc_addr[0] !== 32'h0)    begin n_fail++; $display("FAIL basic_addr0: got %h want 0", acc_addr[0]); end
            if (acc_addr[2] !== 32'h8)    begin n_fail++; $display("FAIL basic_addr2: got %h want 8", acc_addr[2]); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        lat_min = 1; lat_max = 2;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b0;
        repeat (12) tick();
        #1;
        n_cmp += 2;
        if (acc_addr.size() !== 2)  begin n_fail++; $display("FAIL bp_accepts: got %0d want 2", acc_addr.size()); end
        if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL bp_req_valid: got %b want 0", imem_req_valid); end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        repeat (6) tick();
        n_cmp++;
        if (acc_addr.size() !== 3) begin n_fail++; $display("FAIL bp_after_pop: got %0d want 3", acc_addr.size()); end
    endtask

    task automatic test_redirect();
        int base;
        bit old_seen;
        do_reset();
        lat_min = 3; lat_max = 3;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b0;
        for (int i = 0; i < 10 && acc_addr.size() < 2; i++) tick();
        pc_source       = 1'b1;
        redirect_target = 32'h100;
        pop_log.delete();
        base = acc_addr.size();
        tick();
        pc_source   = 1'b0;
        instr_ready = 1'b1;
        base = acc_addr.size();
        for (int i = 0; i < 20 && acc_addr.size() == base; i++) tick();
        repeat (8) tick();
        n_cmp++;
        if (acc_addr.size() == base) begin
            n_fail++;
            $display("FAIL redir_timeout: got no request want addr 00000100");
        end else if (acc_addr[base] !== 32'h100) begin
            n_fail++;
            $display("FAIL redir_addr: got %h want 00000100", acc_addr[base]);
        end
        old_seen = 0;
        foreach (pop_log[i]) if (pop_log[i] < 32'h100) old_seen = 1;
        n_cmp++;
        if (old_seen || pop_log.size() == 0) begin
            n_fail++;
            $display("FAIL redir_old_path: got old=%b pops=%0d want old=0 pops>0", old_seen, pop_log.size());
        end
    endtask

    task automatic test_req_stall();
        do_reset();
        lat_min = 1; lat_max = 1;
        imem_req_ready = 1'b0;
        instr_ready    = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
                n_fail++;
                $display("FAIL stall_hold: got v=%b a=%h want v=1 a=0", imem_req_valid, imem_req_addr);
            end
            tick();
        end
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        #1;
        n_cmp++;
        if (imem_req_addr !== 32'h4 || acc_addr.size() !== 1) begin
            n_fail++;
            $display("FAIL stall_advance: got a=%h n=%0d want a=4 n=1", imem_req_addr, acc_addr.size());
        end
        tick();
    endtask

    task automatic test_wrap();
        int k;
        do_reset();
        lat_min = 1; lat_max = 2;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        repeat (2) tick();
        pc_source       = 1'b1;
        redirect_target = 32'hFFFF_FFF8;
        tick();
        pc_source = 1'b0;
        repeat (14) tick();
        k = -1;
        foreach (acc_addr[i]) if (acc_addr[i] == 32'hFFFF_FFFC && k < 0) k = i;
        n_cmp++;
        if (k < 0 || k + 1 >= acc_addr.size()) begin
            n_fail++;
            $display("FAIL wrap_seq: got idx=%0d n=%0d want fffffffc followed by 0", k, acc_addr.size());
        end else if (acc_addr[k+1] !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_addr: got %h want 00000000", acc_addr[k+1]);
        end
    endtask

    task automatic test_random();
        do_reset();
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 800; i++) begin
            imem_req_ready = ($urandom_range(0, 3) != 0);
            instr_ready    = ($urandom_range(0, 2) != 0);
            pc_source      = ($urandom_range(0, 19) == 0);
            redirect_target = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'hF)) : $urandom();
`ifdef FETCH_MISALIGN_TRAP_EN
            if ($urandom_range(0, 3) != 0) redirect_target[1:0] = 2'b00;
`endif
            tick();
        end
        pc_source = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        lat_min = 2; lat_max = 3;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        repeat (15) tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp += 3;
        if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_req_valid: got %b want 0", imem_req_valid); end
        if (instr_valid !== 1'b0)    begin n_fail++; $display("FAIL midrst_instr_valid: got %b want 0", instr_valid); end
        if (instr !== NOP)           begin n_fail++; $display("FAIL midrst_instr: got %h want %h", instr, NOP); end
        imem_resp_valid = 1'b1;
        imem_resp_data  = $urandom();
        repeat (2) @(posedge clk);
        @(negedge clk);
        imem_resp_valid = 1'b0;
        model_reset();
        rst_n = 1'b1;
        repeat (12) tick();
        n_cmp++;
        if (acc_addr.size() == 0 || acc_addr[0] !== 32'h0) begin
            n_fail++;
            $display("FAIL midrst_restart: got n=%0d want first addr 0", acc_addr.size());
        end
    endtask

`ifdef FETCH_MISALIGN_TRAP_EN
    task automatic test_misalign();
        int base;
        do_reset();
        lat_min = 1; lat_max = 1;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        repeat (4) tick();
        pc_source       = 1'b1;
        redirect_target = 32'h102;
        tick();
        pc_source = 1'b0;
        base = acc_addr.size();
        n_cmp++;
        if (fetch_misaligned !== 1'b1) begin n_fail++; $display("FAIL mis_set: got %b want 1", fetch_misaligned); end
        repeat (6) tick();
        n_cmp += 2;
        if (fetch_misaligned !== 1'b1)  begin n_fail++; $display("FAIL mis_sticky: got %b want 1", fetch_misaligned); end
        if (acc_addr.size() !== base)   begin n_fail++; $display("FAIL mis_no_req: got %0d want %0d", acc_addr.size(), base); end
        pc_source       = 1'b1;
        redirect_target = 32'h200;
        tick();
        pc_source = 1'b0;
        n_cmp++;
        if (fetch_misaligned !== 1'b0) begin n_fail++; $display("FAIL mis_clear: got %b want 0", fetch_misaligned); end
        for (int i = 0; i < 10 && acc_addr.size() == base; i++) tick();
        n_cmp++;
        if (acc_addr.size() == base || acc_addr[base] !== 32'h200) begin
            n_fail++;
            $display("FAIL mis_resume: got n=%0d want addr 00000200", acc_addr.size() - base);
        end
    endtask
`endif

    initial begin
        n_cmp   = 0;
        n_fail  = 0;
        cyc     = 0;
        lat_min = 1;
        lat_max = 1;
        model_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_backpressure();
        test_redirect();
        test_req_stall();
        test_wrap();
        test_random();
        test_reset_mid();
`ifdef FETCH_MISALIGN_TRAP_EN
        test_misalign();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
